vita_ctx_pkt_decoder: RTL and testbench
=======================================

# vita_ctx_pkt_decoder

Host-facing receiver for the VITA context packets emitted by the TX chain's error and flow-control generators. Parses the fifo36 stream, validates each packet, presents stream ID, timestamp, message and sequence number as a one-cycle strobe, and splits packets into error/ack reports and flow-control updates. Flow-control updates feed a credit tracker that gates the upstream TX packet source so it never overruns the deframer's buffering.

## Interface
**Parameters**
- `PROT_ENG_FLAGS`, 0: 1 = first word of every packet is a protocol-engine flags word, which is skipped.
- `MAX_INFLIGHT`, 12'd8: TX packets allowed outstanding before `can_send` drops; legal range 1..4095.

**Ports**
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous; aborts the parse and zeroes the credit counters.
- `data_i` in 36: fifo36 word; [32]=SOF, [33]=EOF, [31:0]=payload.
- `src_rdy_i` in 1: upstream word valid.
- `dst_rdy_o` out 1: decoder ready.
- `expected_sid` in 32: stream ID filter value; used only with the filter macro.
- `pkt_sent` in 1: one-cycle pulse per TX data packet launched.
- `msg_stb` out 1: one-cycle pulse when a valid error/ack packet completes.
- `flow_stb` out 1: one-cycle pulse when a valid flow packet completes.
- `streamid`, `message`, `seqnum` out 32 each: fields of the last valid packet.
- `vita_time` out 64: timestamp of the last valid packet.
- `fmt_err` out 1: one-cycle pulse on a malformed packet.
- `sid_err` out 1: one-cycle pulse on a stream ID mismatch.
- `in_flight` out 12: outstanding TX packets.
- `can_send` out 1: `in_flight < MAX_INFLIGHT`.

## Operation
- Packet layout after the optional flags word, 6 words:
  - HDR: [31:28] = 4'h4 or 4'h5; [15:0] = 16'd6.
  - SID.
  - TIME_HI, TIME_LO.
  - MSG.
  - SEQ.
- FSM states: IDLE, FLAGS, HDR, SID, THI, TLO, MSG, SEQ, DRAIN.
- IDLE:
  - On a word with SOF, go to FLAGS if `PROT_ENG_FLAGS`, otherwise treat the word as HDR.
  - A word without SOF is discarded.
- Each accepted word advances one state. Fields are captured into shadow registers.
- The SEQ word must carry EOF. If valid, copy the shadow registers to the outputs and pulse either `msg_stb` (MSG != 0) or `flow_stb` (MSG == 0), then return to IDLE.
- Format errors: bad type, length != 6, EOF before SEQ, or SEQ without EOF.
  - Pulse `fmt_err` once. Outputs are not updated.
  - If EOF has not yet been seen, go to DRAIN; DRAIN discards words up to and including EOF.
  - A SOF arriving mid-packet outside DRAIN is a format error; the new SOF word is treated as a fresh HDR.
- Credit tracker:
  - `sent_cnt` (12 bit) increments on `pkt_sent`.
  - `consumed` (12 bit) loads `SEQ[11:0]` on `flow_stb`.
  - `in_flight = sent_cnt - consumed`, mod 4096.
  - `pkt_sent` and `flow_stb` in the same cycle both take effect.
- `clear`: FSM returns to IDLE and both counters go to 0. Output field registers are held. `clear` has priority over all events that cycle.

## Timing
- Reset values:
  - Outputs: `dst_rdy_o`=0, all strobes and error pulses 0, all fields 0, `in_flight`=0, `can_send`=1.
  - State: FSM in IDLE.
- `dst_rdy_o` is 1 from the first clock after reset release; the decoder never back-pressures.
- A word is accepted when `src_rdy_i & dst_rdy_o`.
- Strobes are registered and assert the cycle after the SEQ word is accepted. Fields are valid in that same cycle and stay stable until the next valid packet.
- `in_flight` and `can_send` are registered and update one cycle after the `pkt_sent` or `flow_stb` cycle.
- An async reset mid-packet discards the partial packet.

## Configuration
- `VITA_CTX_SID_FILTER_EN` defined: a valid packet whose SID != `expected_sid` pulses `sid_err` instead of `msg_stb`/`flow_stb`, and neither outputs nor `consumed` are updated.
- `VITA_CTX_SID_FILTER_EN` undefined: `expected_sid` is ignored and `sid_err` is tied to 0.

## Test plan
- Flow packet SID=0x1234, TIME=0x0000_0001_0000_0002, MSG=0, SEQ=5 -> `flow_stb` once, `seqnum`=5, `msg_stb`=0.
- 7 `pkt_sent` pulses, then flow SEQ=2 -> `in_flight` 7 then 5; `can_send`=1. An 8th pulse with no flow packet -> `in_flight`=6.
- `sent_cnt` wrapped to 3, flow SEQ=4093 -> `in_flight`=6 (mod 4096).
- Header length field=7 -> one `fmt_err`, rest of packet drained, outputs unchanged. The next valid packet decodes normally.
- Error packet MSG=0x0000_0002 with `pkt_sent` in the same cycle as the SEQ word -> `msg_stb`=1, `consumed` unchanged, `in_flight`+1.
- With the macro, SID=0x1 and `expected_sid`=0x2 -> `sid_err`=1, no strobe. `clear` mid-packet -> IDLE, counters 0.

Source files
------------

// File: rtl/vita_ctx_pkt_decoder.sv
// vita_ctx_pkt_decoder: receives VITA context packets from a fifo36 stream, validates them,
// strobes out the decoded fields and tracks TX credits from flow-control updates.
// Optional build macro: VITA_CTX_SID_FILTER_EN enables the stream ID filter (sid_err).
module vita_ctx_pkt_decoder #(
    parameter int unsigned PROT_ENG_FLAGS = 0,
    parameter logic [11:0] MAX_INFLIGHT   = 12'd8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic [35:0] data_i,
    input  logic        src_rdy_i,
    output logic        dst_rdy_o,
    input  logic [31:0] expected_sid,
    input  logic        pkt_sent,
    output logic        msg_stb,
    output logic        flow_stb,
    output logic [31:0] streamid,
    output logic [31:0] message,
    output logic [31:0] seqnum,
    output logic [63:0] vita_time,
    output logic        fmt_err,
    output logic        sid_err,
    output logic [11:0] in_flight,
    output logic        can_send
);

    // State names the last word consumed; StSeq is the cycle after a completed packet.
    typedef enum logic [3:0] {
        StIdle, StFlags, StHdr, StSid, StThi, StTlo, StMsg, StSeq, StDrain
    } state_e;

    state_e      state_q, state_d;
    logic        dst_rdy_q;
    logic [31:0] sid_sh_q, sid_sh_d, thi_sh_q, thi_sh_d;
    logic [31:0] tlo_sh_q, tlo_sh_d, msg_sh_q, msg_sh_d;
    logic [31:0] streamid_q, message_q, seqnum_q;
    logic [63:0] vita_time_q;
    logic        msg_stb_q, flow_stb_q, fmt_err_q, sid_err_q;
    logic        fmt_err_d, commit, take_hdr, sid_match, upd_fields;
    logic [11:0] sent_q, sent_d, cons_q, cons_d, in_flight_q, in_flight_d;
    logic        can_send_q;
    logic        accept, sof, eof, hdr_ok;

    assign accept = src_rdy_i & dst_rdy_q;
    assign sof    = data_i[32];
    assign eof    = data_i[33];
    assign hdr_ok = ((data_i[31:28] == 4'h4) || (data_i[31:28] == 4'h5)) &&
                    (data_i[15:0] == 16'd6);

`ifdef VITA_CTX_SID_FILTER_EN
    assign sid_match = (sid_sh_q == expected_sid);
`else
    logic unused_expected_sid;
    assign unused_expected_sid = ^expected_sid;
    assign sid_match = 1'b1;
`endif

    assign upd_fields = commit & sid_match;

    // Parser next-state, shadow capture and error detection.
    always_comb begin
        state_d   = state_q;
        sid_sh_d  = sid_sh_q;
        thi_sh_d  = thi_sh_q;
        tlo_sh_d  = tlo_sh_q;
        msg_sh_d  = msg_sh_q;
        fmt_err_d = 1'b0;
        commit    = 1'b0;
        take_hdr  = 1'b0;
        if (accept) begin
            unique case (state_q)
                StIdle, StSeq: begin
                    state_d = StIdle;
                    if (sof) begin
                        if (PROT_ENG_FLAGS != 0) begin
                            if (eof) fmt_err_d = 1'b1;
                            else     state_d   = StFlags;
                        end else begin
                            take_hdr = 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (eof) state_d = StIdle;
                end
                default: begin
                    if (sof) begin
                        // A new packet cut into this one: report it and restart on this word.
                        fmt_err_d = 1'b1;
                        take_hdr  = 1'b1;
                    end else if (eof && (state_q != StMsg)) begin
                        fmt_err_d = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        unique case (state_q)
                            StFlags: take_hdr = 1'b1;
                            StHdr: begin
                                sid_sh_d = data_i[31:0];
                                state_d  = StSid;
                            end
                            StSid: begin
                                thi_sh_d = data_i[31:0];
                                state_d  = StThi;
                            end
                            StThi: begin
                                tlo_sh_d = data_i[31:0];
                                state_d  = StTlo;
                            end
                            StTlo: begin
                                msg_sh_d = data_i[31:0];
                                state_d  = StMsg;
                            end
                            StMsg: begin
                                if (eof) begin
                                    commit  = 1'b1;
                                    state_d = StSeq;
                                end else begin
                                    fmt_err_d = 1'b1;
                                    state_d   = StDrain;
                                end
                            end
                            default: state_d = StIdle;
                        endcase
                    end
                end
            endcase
            if (take_hdr) begin
                if (!hdr_ok || eof) begin
                    fmt_err_d = 1'b1;
                    state_d   = eof ? StIdle : StDrain;
                end else begin
                    state_d = StHdr;
                end
            end
        end else if (state_q == StSeq) begin
            state_d = StIdle;
        end
        if (clear) begin
            state_d   = StIdle;
            fmt_err_d = 1'b0;
            commit    = 1'b0;
        end
    end

    // Credit counters; clear wins over pkt_sent and flow updates.
    always_comb begin
        sent_d = sent_q;
        cons_d = cons_q;
        if (clear) begin
            sent_d = '0;
            cons_d = '0;
        end else begin
            if (pkt_sent)   sent_d = sent_q + 12'd1;
            if (flow_stb_q) cons_d = seqnum_q[11:0];
        end
        in_flight_d = sent_d - cons_d;
    end

    // Parser state, shadow fields and ready flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            dst_rdy_q <= 1'b0;
            sid_sh_q  <= '0;
            thi_sh_q  <= '0;
            tlo_sh_q  <= '0;
            msg_sh_q  <= '0;
        end else begin
            state_q   <= state_d;
            dst_rdy_q <= 1'b1;
            sid_sh_q  <= sid_sh_d;
            thi_sh_q  <= thi_sh_d;
            tlo_sh_q  <= tlo_sh_d;
            msg_sh_q  <= msg_sh_d;
        end
    end

    // Output fields and one-cycle strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            streamid_q  <= '0;
            message_q   <= '0;
            seqnum_q    <= '0;
            vita_time_q <= '0;
            msg_stb_q   <= 1'b0;
            flow_stb_q  <= 1'b0;
            fmt_err_q   <= 1'b0;
            sid_err_q   <= 1'b0;
        end else begin
            msg_stb_q  <= upd_fields & (msg_sh_q != 32'd0);
            flow_stb_q <= upd_fields & (msg_sh_q == 32'd0);
            fmt_err_q  <= fmt_err_d;
            sid_err_q  <= commit & ~sid_match;
            if (upd_fields) begin
                streamid_q  <= sid_sh_q;
                message_q   <= msg_sh_q;
                seqnum_q    <= data_i[31:0];
                vita_time_q <= {thi_sh_q, tlo_sh_q};
            end
        end
    end

    // Credit tracker registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sent_q      <= '0;
            cons_q      <= '0;
            in_flight_q <= '0;
            can_send_q  <= 1'b1;
        end else begin
            sent_q      <= sent_d;
            cons_q      <= cons_d;
            in_flight_q <= in_flight_d;
            can_send_q  <= (in_flight_d < MAX_INFLIGHT);
        end
    end

    assign dst_rdy_o = dst_rdy_q;
    assign msg_stb   = msg_stb_q;
    assign flow_stb  = flow_stb_q;
    assign streamid  = streamid_q;
    assign message   = message_q;
    assign seqnum    = seqnum_q;
    assign vita_time = vita_time_q;
    assign fmt_err   = fmt_err_q;
    assign sid_err   = sid_err_q;
    assign in_flight = in_flight_q;
    assign can_send  = can_send_q;

endmodule

// File: tb/tb_vita_ctx_pkt_decoder.sv
// Scoreboard bench for vita_ctx_pkt_decoder: stimulus pushes expected events,
// a negedge monitor pops and compares whenever a strobe or error pulse appears.
module tb_vita_ctx_pkt_decoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic [35:0] data_i = '0;
    logic        src_rdy_i = 1'b0;
    logic        dst_rdy_o;
    logic [31:0] expected_sid = 32'h1234;
    logic        pkt_sent = 1'b0;
    logic        msg_stb, flow_stb, fmt_err, sid_err, can_send;
    logic [31:0] streamid, message, seqnum;
    logic [63:0] vita_time;
    logic [11:0] in_flight;

    vita_ctx_pkt_decoder dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .data_i(data_i),
        .src_rdy_i(src_rdy_i), .dst_rdy_o(dst_rdy_o), .expected_sid(expected_sid),
        .pkt_sent(pkt_sent), .msg_stb(msg_stb), .flow_stb(flow_stb),
        .streamid(streamid), .message(message), .seqnum(seqnum), .vita_time(vita_time),
        .fmt_err(fmt_err), .sid_err(sid_err), .in_flight(in_flight), .can_send(can_send)
    );

    always #5 clk = ~clk;

    // Event bits {msg_stb, flow_stb, fmt_err, sid_err}.
    localparam logic [3:0] EvMsg = 4'b1000, EvFlow = 4'b0100, EvFmt = 4'b0010, EvSid = 4'b0001;

    typedef struct packed {
        logic [3:0]  stb;
        logic [31:0] sid;
        logic [63:0] t;
        logic [31:0] msg;
        logic [31:0] seq;
    } evt_t;

    evt_t        sb[$];
    evt_t        mon_e;
    int          ntotal = 0;
    int          npass = 0;
    logic [31:0] m_sid = '0, m_msg = '0, m_seq = '0;
    logic [63:0] m_t = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_evt(input logic [3:0] stb);
        evt_t e;
        e.stb = stb; e.sid = m_sid; e.t = m_t; e.msg = m_msg; e.seq = m_seq;
        sb.push_back(e);
    endtask

    task automatic push_good(input logic [31:0] sid, input logic [63:0] t,
                             input logic [31:0] msg, input logic [31:0] seq);
        m_sid = sid; m_t = t; m_msg = msg; m_seq = seq;
        push_evt((msg != 32'd0) ? EvMsg : EvFlow);
    endtask

    task automatic word(input logic s, input logic e, input logic [31:0] p, input logic sent);
        data_i    = {2'b00, e, s, p};
        src_rdy_i = 1'b1;
        pkt_sent  = sent;
        @(posedge clk); #1;
        src_rdy_i = 1'b0;
        pkt_sent  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sent_pulses(input int n);
        pkt_sent = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        pkt_sent = 1'b0;
    endtask

    task automatic pkt(input logic [31:0] sid, input logic [63:0] t, input logic [31:0] msg,
                       input logic [31:0] seq, input logic sent_on_seq, input logic mismatch);
        expected_sid = mismatch ? sid + 32'd1 : sid;
`ifdef VITA_CTX_SID_FILTER_EN
        if (mismatch) push_evt(EvSid);
        else          push_good(sid, t, msg, seq);
`else
        push_good(sid, t, msg, seq);
`endif
        word(1'b1, 1'b0, 32'h4000_0006, 1'b0);
        word(1'b0, 1'b0, sid, 1'b0);
        word(1'b0, 1'b0, t[63:32], 1'b0);
        word(1'b0, 1'b0, t[31:0], 1'b0);
        word(1'b0, 1'b0, msg, 1'b0);
        word(1'b0, 1'b1, seq, sent_on_seq);
    endtask

    task automatic credit(input string name, input logic [11:0] inf, input logic cs);
        chk({name, "_in_flight"}, in_flight, inf);
        chk({name, "_can_send"}, can_send, cs);
    endtask

    // Monitor: every strobe or error pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (reset_n && (msg_stb || flow_stb || fmt_err || sid_err)) begin
            if (sb.size() == 0) begin
                ntotal++;
                $display("FAIL unexpected_event: got %b expected none",
                         {msg_stb, flow_stb, fmt_err, sid_err});
            end else begin
                mon_e = sb.pop_front();
                chk("evt_kind", {msg_stb, flow_stb, fmt_err, sid_err}, mon_e.stb);
                chk("evt_streamid", streamid, mon_e.sid);
                chk("evt_vita_time", vita_time, mon_e.t);
                chk("evt_message", message, mon_e.msg);
                chk("evt_seqnum", seqnum, mon_e.seq);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        chk("rst_dst_rdy", dst_rdy_o, 1'b0);
        chk("rst_strobes", {msg_stb, flow_stb, fmt_err, sid_err}, 4'b0000);
        chk("rst_fields", {streamid, message, seqnum}, 96'd0);
        chk("rst_time", vita_time, 64'd0);
        credit("rst", 12'd0, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("dst_rdy_after_reset", dst_rdy_o, 1'b1);

        // Stray non-SOF word in idle is discarded.
        word(1'b0, 1'b1, 32'hCAFE_0000, 1'b0);
        // Flow packet with nothing sent: 0 - 5 mod 4096.
        pkt(32'h1234, 64'h0000_0001_0000_0002, 32'd0, 32'd5, 1'b0, 1'b0);
        idle(3);
        credit("flow5", 12'd4091, 1'b0);

        clear = 1'b1; idle(1); clear = 1'b0;
        credit("clear1", 12'd0, 1'b1);
        sent_pulses(7);
        credit("sent7", 12'd7, 1'b1);
        pkt(32'h55, 64'hDEAD_BEEF_0123_4567, 32'd0, 32'd2, 1'b0, 1'b0);
        idle(3);
        credit("flow2", 12'd5, 1'b1);
        sent_pulses(1);
        credit("sent8", 12'd6, 1'b1);

        // Counter wrap: 4099 sends leave sent_cnt at 3.
        clear = 1'b1; idle(1); clear = 1'b0;
        sent_pulses(8);
        credit("limit", 12'd8, 1'b0);
        sent_pulses(4091);
        credit("wrap", 12'd3, 1'b1);
        pkt(32'hA5A5, 64'h1111_2222_3333_4444, 32'd0, 32'd4093, 1'b0, 1'b0);
        idle(3);
        credit("wrap_flow", 12'd6, 1'b1);

        // Length 7: one fmt_err, remainder drained, fields unchanged.
        push_evt(EvFmt);
        word(1'b1, 1'b0, 32'h4000_0007, 1'b0);
        for (int i = 0; i < 4; i++) word(1'b0, 1'b0, 32'h10 + i, 1'b0);
        word(1'b0, 1'b1, 32'd9, 1'b0);
        idle(3);
        credit("badlen", 12'd6, 1'b1);

        // Error packet with pkt_sent on the SEQ word.
        pkt(32'h1234, 64'h0000_00AB_0000_00CD, 32'd2, 32'd77, 1'b1, 1'b0);
        idle(3);
        credit("msg_sent", 12'd7, 1'b1);

        // Bad type.
        push_evt(EvFmt);
        word(1'b1, 1'b0, 32'h3000_0006, 1'b0);
        for (int i = 0; i < 4; i++) word(1'b0, 1'b0, 32'h20 + i, 1'b0);
        word(1'b0, 1'b1, 32'd1, 1'b0);
        // EOF before SEQ, then stray words.
        push_evt(EvFmt);
        word(1'b1, 1'b0, 32'h5000_0006, 1'b0);
        word(1'b0, 1'b0, 32'h1, 1'b0);
        word(1'b0, 1'b1, 32'h2, 1'b0);
        word(1'b0, 1'b0, 32'h3, 1'b0);
        word(1'b0, 1'b1, 32'h4, 1'b0);
        // SEQ without EOF, then drain.
        push_evt(EvFmt);
        word(1'b1, 1'b0, 32'h4000_0006, 1'b0);
        for (int i = 0; i < 5; i++) word(1'b0, 1'b0, 32'h30 + i, 1'b0);
        word(1'b0, 1'b0, 32'h40, 1'b0);
        word(1'b0, 1'b1, 32'h41, 1'b0);
        // SOF mid-packet restarts on a fresh header.
        push_evt(EvFmt);
        word(1'b1, 1'b0, 32'h4000_0006, 1'b0);
        word(1'b0, 1'b0, 32'h99, 1'b0);
        pkt(32'hBEEF, 64'h0000_0005_0000_0006, 32'h8000_0001, 32'd12, 1'b0, 1'b0);
        idle(3);
        credit("after_errs", 12'd7, 1'b1);

        // Clear mid-packet (with a simultaneous pkt_sent): rest of packet is discarded.
        word(1'b1, 1'b0, 32'h4000_0006, 1'b0);
        word(1'b0, 1'b0, 32'h1234, 1'b0);
        clear = 1'b1; pkt_sent = 1'b1;
        idle(1);
        clear = 1'b0; pkt_sent = 1'b0;
        word(1'b0, 1'b0, 32'h0, 1'b0);
        word(1'b0, 1'b0, 32'h0, 1'b0);
        word(1'b0, 1'b0, 32'h0, 1'b0);
        word(1'b0, 1'b1, 32'd50, 1'b0);
        idle(3);
        credit("clear_mid", 12'd0, 1'b1);
        pkt(32'h777, 64'h0000_0000_0000_0099, 32'd3, 32'd9, 1'b0, 1'b0);
        idle(3);

        // SID mismatch on a flow packet (SID 1, expected 2).
        pkt(32'h1, 64'h0000_0007_0000_0008, 32'd0, 32'd100, 1'b0, 1'b1);
        idle(3);
`ifdef VITA_CTX_SID_FILTER_EN
        credit("sid_mismatch", 12'd0, 1'b1);
`else
        credit("sid_ignored", 12'd3996, 1'b0);
`endif

        idle(5);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
